ram_rr_arbiter: RTL and testbench

RAM_RR_ARBITER -- requirements
Module: ram_rr_arbiter

---
 rtl/ram_rr_arbiter.sv | 177 +++++++++++++++++
 tb/tb_ram_rr_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ram_rr_arbiter
//  Purpose  : Round-robin arbiter feeding one 1-cycle-latency RAM from
//             NUM_PORTS requesters; burst lock compiled in with RAM_ARB_LOCK_EN.
//  Revision : 1.0
// ============================================================================
module ram_rr_arbiter #(
    parameter int NUM_PORTS  = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_LOCK   = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_PORTS-1:0]              req_i,
    output logic [NUM_PORTS-1:0]              gnt_o,
    output logic [NUM_PORTS-1:0]              rvalid_o,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   addr_i,
    input  logic [NUM_PORTS-1:0]              we_i,
    input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] be_i,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]   wdata_i,
    output logic [DATA_WIDTH-1:0]             rdata_o,
`ifdef RAM_ARB_LOCK_EN
    input  logic [NUM_PORTS-1:0]              lock_i,
`endif
    output logic                              ram_en_o,
    output logic [ADDR_WIDTH-1:0]             ram_addr_o,
    output logic                              ram_we_o,
    output logic [DATA_WIDTH/8-1:0]           ram_be_o,
    output logic [DATA_WIDTH-1:0]             ram_wdata_o,
    input  logic [DATA_WIDTH-1:0]             ram_rdata_i
);

    localparam int c_BE_W  = DATA_WIDTH / 8;
    localparam int c_PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [c_PTR_W-1:0]   r_ptr;
    logic [c_PTR_W-1:0]   w_ptr_nxt;
    logic [NUM_PORTS-1:0] r_rvalid;

    logic [c_PTR_W-1:0]   w_search_ptr;
    logic [c_PTR_W-1:0]   w_cand;
    logic [NUM_PORTS-1:0] w_rr_gnt;
    logic [c_PTR_W-1:0]   w_rr_idx;
    logic                 w_rr_any;

    logic [NUM_PORTS-1:0] w_gnt;
    logic [c_PTR_W-1:0]   w_gnt_idx;
    logic                 w_gnt_any;

    // First requester at or after the search pointer, wrapping modulo NUM_PORTS.
    always_comb begin
        w_rr_gnt = '0;
        w_rr_idx = '0;
        w_rr_any = 1'b0;
        w_cand   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_cand = c_PTR_W'((int'(w_search_ptr) + i) % NUM_PORTS);
            if (!w_rr_any && req_i[w_cand]) begin
                w_rr_any         = 1'b1;
                w_rr_idx         = w_cand;
                w_rr_gnt[w_cand] = 1'b1;
            end
        end
    end

`ifdef RAM_ARB_LOCK_EN
    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_PTR_W-1:0] r_owner;
    logic [c_PTR_W-1:0] w_owner_nxt;
    logic [c_PTR_W-1:0] w_owner_inc;
    logic [7:0]         r_beats;
    logic [7:0]         w_beats_nxt;
    logic               w_hold;

    assign w_owner_inc  = c_PTR_W'((int'(r_owner) + 1) % NUM_PORTS);
    assign w_hold       = (r_state == ST_LOCKED) && req_i[r_owner];
    // An absent owner releases the lock and the others compete from owner+1.
    assign w_search_ptr = (r_state == ST_LOCKED) ? w_owner_inc : r_ptr;

    always_comb begin
        w_gnt       = w_rr_gnt;
        w_gnt_idx   = w_rr_idx;
        w_gnt_any   = w_rr_any;
        w_state_nxt = ST_IDLE;
        w_owner_nxt = r_owner;
        w_beats_nxt = '0;
        if (w_hold) begin
            w_gnt            = '0;
            w_gnt[r_owner]   = 1'b1;
            w_gnt_idx        = r_owner;
            w_gnt_any        = 1'b1;
            if (lock_i[r_owner] && ({1'b0, r_beats} + 9'd1) < 9'(MAX_LOCK)) begin
                w_state_nxt = ST_LOCKED;
                w_beats_nxt = r_beats + 8'd1;
            end
        end else if (w_rr_any && lock_i[w_rr_idx] && MAX_LOCK > 1) begin
            w_state_nxt = ST_LOCKED;
            w_owner_nxt = w_rr_idx;
            w_beats_nxt = 8'd1;
        end
    end

    always_comb begin
        w_ptr_nxt = r_ptr;
        if (w_gnt_any) begin
            w_ptr_nxt = c_PTR_W'((int'(w_gnt_idx) + 1) % NUM_PORTS);
        end else if (r_state == ST_LOCKED) begin
            w_ptr_nxt = w_owner_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_owner <= '0;
            r_beats <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_beats <= w_beats_nxt;
        end
    end
`else
    assign w_search_ptr = r_ptr;
    assign w_gnt        = w_rr_gnt;
    assign w_gnt_idx    = w_rr_idx;
    assign w_gnt_any    = w_rr_any;

    always_comb begin
        w_ptr_nxt = r_ptr;
        if (w_gnt_any) begin
            w_ptr_nxt = c_PTR_W'((int'(w_gnt_idx) + 1) % NUM_PORTS);
        end
    end
`endif

    // Granted port's command to the RAM; all zero when nothing is granted.
    always_comb begin
        ram_addr_o  = '0;
        ram_we_o    = 1'b0;
        ram_be_o    = '0;
        ram_wdata_o = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (w_gnt[k]) begin
                ram_addr_o  = addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
                ram_we_o    = we_i[k];
                ram_be_o    = be_i[k*c_BE_W +: c_BE_W];
                ram_wdata_o = wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign ram_en_o = w_gnt_any;
    assign gnt_o    = w_gnt;
    assign rvalid_o = r_rvalid;
    assign rdata_o  = ram_rdata_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr    <= '0;
            r_rvalid <= '0;
        end else begin
            r_ptr    <= w_ptr_nxt;
            r_rvalid <= w_gnt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ram_rr_arbiter
//  Purpose  : Directed bench for ram_rr_arbiter with an rvalid/rdata scoreboard;
//             lock scenarios run when RAM_ARB_LOCK_EN is defined.
//  Revision : 1.0
// ============================================================================
module tb_ram_rr_arbiter;

    localparam int NP = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [NP-1:0]   req_i;
    logic [NP-1:0]   gnt_o;
    logic [NP-1:0]   rvalid_o;
    logic [NP*AW-1:0] addr_i;
    logic [NP-1:0]   we_i;
    logic [NP*BW-1:0] be_i;
    logic [NP*DW-1:0] wdata_i;
    logic [DW-1:0]   rdata_o;
    logic [NP-1:0]   lock_v;
    logic            ram_en_o;
    logic [AW-1:0]   ram_addr_o;
    logic            ram_we_o;
    logic [BW-1:0]   ram_be_o;
    logic [DW-1:0]   ram_wdata_o;
    logic [DW-1:0]   ram_rdata_i;

    logic [AW-1:0]   addr_a [NP];
    logic [BW-1:0]   be_a   [NP];
    logic [DW-1:0]   wd_a   [NP];
    logic [DW-1:0]   mem    [64];

    typedef struct {
        logic [NP-1:0] rv;
        logic          chk;
        logic [DW-1:0] data;
    } exp_t;
    exp_t sb[$];

    int checks   = 0;
    int failures = 0;
    logic mon_en = 1'b0;

    always #5 clk = ~clk;

    ram_rr_arbiter #(
        .NUM_PORTS  (NP),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .MAX_LOCK   (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req_i),
        .gnt_o       (gnt_o),
        .rvalid_o    (rvalid_o),
        .addr_i      (addr_i),
        .we_i        (we_i),
        .be_i        (be_i),
        .wdata_i     (wdata_i),
        .rdata_o     (rdata_o),
`ifdef RAM_ARB_LOCK_EN
        .lock_i      (lock_v),
`endif
        .ram_en_o    (ram_en_o),
        .ram_addr_o  (ram_addr_o),
        .ram_we_o    (ram_we_o),
        .ram_be_o    (ram_be_o),
        .ram_wdata_o (ram_wdata_o),
        .ram_rdata_i (ram_rdata_i)
    );

    always_comb begin
        addr_i  = '0;
        be_i    = '0;
        wdata_i = '0;
        for (int k = 0; k < NP; k++) begin
            addr_i[k*AW +: AW]  = addr_a[k];
            be_i[k*BW +: BW]    = be_a[k];
            wdata_i[k*DW +: DW] = wd_a[k];
        end
    end

    // One-cycle RAM: word k holds 0x1000_0000+k, word 16 (0x40) holds DEADBEEF.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h1000_0000 + 32'(i);
            mem[16]     <= 32'hDEAD_BEEF;
            ram_rdata_i <= '0;
        end else if (ram_en_o) begin
            for (int b = 0; b < BW; b++)
                if (ram_we_o && ram_be_o[b]) mem[ram_addr_o[7:2]][8*b +: 8] <= ram_wdata_o[8*b +: 8];
            ram_rdata_i <= mem[ram_addr_o[7:2]];
        end
    end

    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
        return (a == 32'h40) ? 32'hDEAD_BEEF : 32'h1000_0000 + {26'd0, a[7:2]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [NP-1:0] r, input logic [NP-1:0] l);
        req_i  = r;
        lock_v = l;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called at a negedge: checks the combinational grant path, queues the response.
    task automatic sample(input logic [NP-1:0] exp_gnt, input string name);
        int idx;
        idx = 0;
        check({name, " gnt"}, 64'(gnt_o), 64'(exp_gnt));
        if (exp_gnt == '0) begin
            check({name, " ram_en"}, 64'(ram_en_o), 64'd0);
            check({name, " ram_addr"}, 64'(ram_addr_o), 64'd0);
        end else begin
            for (int k = 0; k < NP; k++) if (exp_gnt[k]) idx = k;
            check({name, " ram_en"}, 64'(ram_en_o), 64'd1);
            check({name, " ram_addr"}, 64'(ram_addr_o), 64'(addr_a[idx]));
            check({name, " ram_we"}, 64'(ram_we_o), 64'(we_i[idx]));
            check({name, " ram_be"}, 64'(ram_be_o), 64'(be_a[idx]));
            check({name, " ram_wdata"}, 64'(ram_wdata_o), 64'(wd_a[idx]));
            if (!rst) sb.push_back('{rv: exp_gnt, chk: !we_i[idx], data: exp_rd(addr_a[idx])});
        end
    endtask

    task automatic cyc(input logic [NP-1:0] r, input logic [NP-1:0] l,
                       input logic [NP-1:0] exp_gnt, input string name);
        drive(r, l);
        @(negedge clk);
        sample(exp_gnt, name);
        step();
    endtask

    // Monitor: every rvalid must match the oldest queued grant.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en && rvalid_o !== '0) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected rvalid: got %0h expected none", rvalid_o);
                end else begin
                    e = sb.pop_front();
                    check("rvalid", 64'(rvalid_o), 64'(e.rv));
                    if (e.chk) check("rdata", 64'(rdata_o), 64'(e.data));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < NP; k++) begin
            addr_a[k] = 32'(k * 4);
            be_a[k]   = '1;
            wd_a[k]   = 32'h0;
        end
        we_i = '0;
        rst  = 1'b1;
        drive('0, '0);
        step();
        step();
        @(negedge clk);
        check("reset rvalid", 64'(rvalid_o), 64'd0);
        sample('0, "reset");
        step();
        rst    = 1'b0;
        mon_en = 1'b1;

        // All four requesting: strict rotation with no bubbles.
        for (int i = 0; i < 8; i++) cyc(4'hF, '0, 4'(1 << (i % 4)), "rr_all");

        // Single read from port 2 at 0x40.
        addr_a[2] = 32'h40;
        cyc(4'b0100, '0, 4'b0100, "port2_read");
        addr_a[2] = 32'h8;

        // Idle cycles leave the pointer at 3.
        for (int i = 0; i < 5; i++) cyc('0, '0, '0, "idle");
        cyc(4'hF, '0, 4'b1000, "after_idle");

        // Write from port 1.
        we_i[1]   = 1'b1;
        be_a[1]   = 4'b0011;
        wd_a[1]   = 32'hAAAA_5555;
        addr_a[1] = 32'hFC;
        cyc(4'b0010, '0, 4'b0010, "port1_write");
        we_i[1]   = 1'b0;
        be_a[1]   = '1;
        wd_a[1]   = '0;
        addr_a[1] = 32'h4;

        // Reset right after a grant to port 3 drops the follow-on response.
        cyc(4'b1000, '0, 4'b1000, "port3_pre_rst");
        rst = 1'b1;
        cyc(4'b0100, '0, 4'b0100, "gnt_in_rst");
        rst = 1'b0;
        drive(4'b1010, '0);
        @(negedge clk);
        check("rvalid after rst", 64'(rvalid_o), 64'd0);
        sample(4'b0010, "post_rst");
        step();

`ifdef RAM_ARB_LOCK_EN
        // Port 1 locks for MAX_LOCK beats, then rotation resumes at port 2.
        rst = 1'b1;
        cyc('0, '0, '0, "lock_rst_a");
        rst = 1'b0;
        cyc(4'b0001, '0, 4'b0001, "set_ptr1");
        for (int i = 0; i < 8; i++) cyc(4'b1011, 4'b0010, 4'b0010, "lock_beat");
        cyc(4'b1011, 4'b0010, 4'b1000, "lock_done_p3");
        cyc(4'b1011, 4'b0010, 4'b0001, "lock_done_p0");

        // Owner drops its request: port 2 wins in the same cycle.
        rst = 1'b1;
        cyc('0, '0, '0, "lock_rst_b");
        rst = 1'b0;
        for (int i = 0; i < 3; i++) cyc(4'b0101, 4'b0001, 4'b0001, "lock0_beat");
        cyc(4'b0100, '0, 4'b0100, "owner_drop");
        cyc(4'b0011, '0, 4'b0001, "after_drop");
`endif

        drive('0, '0);
        step();
        step();
        check("scoreboard drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
